// File: rtl/pe_filter_receiver.sv
// pe_filter_receiver
//   PE-side receiver for one lane of the weight buffer's six-lane filter packet
//   stream. Collects the three 32-bit beats of every layer addressed to this
//   lane into NUM_LAYERS rows of 88 bits (11 byte columns each). It raises
//   filter_ready once the whole set is held and serves byte reads to the MAC
//   datapath. Layer-order violations, overruns and truncated transfers are
//   flagged.
//
// Ports
//   clk           clock
//   rst_n         asynchronous reset, active HIGH despite the name
//   packet_in     lane packet {data[31:0], valid, packet_idx[4:0]} packed MSB
//                 first: data=[37:6], valid=[5], packet_idx=[4:0] with
//                 packet_idx = {layer[1:0], lane[2:0]}
//   finish_in     end-of-stream pulse from the weight buffer
//   clear         flush request from the controller
//   rd_en         byte read request
//   rd_layer      row (layer) to read
//   rd_col        byte column 0..10 to read
//   filter_ready  complete filter set held
//   rd_valid      rd_data valid (one cycle after rd_en)
//   rd_data       filter byte, 0 when the set is not complete or out of range
//   seq_err       sticky: wrong layer index, or a beat arrived while full
//   incomplete    sticky: finish_in seen with a partial set
module pe_filter_receiver #(
  parameter int unsigned PE_ID      = 0,
  parameter int unsigned NUM_LAYERS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [37:0] packet_in,
  input  logic        finish_in,
  input  logic        clear,
  input  logic        rd_en,
  input  logic [1:0]  rd_layer,
  input  logic [3:0]  rd_col,
  output logic        filter_ready,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        seq_err,
  output logic        incomplete
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ROW_W    = 88;
  localparam int unsigned NUM_COLS = 11;
  localparam int unsigned LANE_W   = 3;
  localparam int unsigned LAYER_W  = 2;
  localparam int unsigned BEAT_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                state_q, state_nxt;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_nxt;
  logic [LAYER_W-1:0]    layer_cnt_q, layer_cnt_nxt;
  logic [ROW_W-1:0]      row_q [NUM_LAYERS];

  logic [DATA_W-1:0]     pkt_data_c;
  logic                  pkt_valid_c;
  logic [LAYER_W-1:0]    pkt_layer_c;
  logic [LANE_W-1:0]     pkt_lane_c;

  logic                  beat_hit_c;
  logic                  layer_ok_c;
  logic                  last_beat_c;
  logic                  wr_en_c;
  logic                  seq_err_set_c;
  logic                  incomplete_set_c;
  logic                  flags_clr_c;

  logic [ROW_W-1:0]      rd_row_c;
  logic [7:0]            rd_byte_c;

  // Unpack the lane packet.
  assign pkt_data_c  = packet_in[37:6];
  assign pkt_valid_c = packet_in[5];
  assign pkt_layer_c = packet_in[4:3];
  assign pkt_lane_c  = packet_in[2:0];

  // Beat addressed to this lane, whether or not it is in order.
  assign beat_hit_c  = pkt_valid_c && (pkt_lane_c == LANE_W'(PE_ID));
  assign layer_ok_c  = (pkt_layer_c == layer_cnt_q);
  assign last_beat_c = (beat_cnt_q == BEAT_W'(2)) &&
                       (layer_cnt_q == LAYER_W'(NUM_LAYERS - 1));

  // Next-state, counter and flag control.
  always_comb begin
    state_nxt        = state_q;
    beat_cnt_nxt     = beat_cnt_q;
    layer_cnt_nxt    = layer_cnt_q;
    wr_en_c          = 1'b0;
    seq_err_set_c    = 1'b0;
    incomplete_set_c = 1'b0;
    flags_clr_c      = 1'b0;

    if (clear) begin
      // Flush wins over any beat or finish in the same cycle.
      state_nxt     = IDLE;
      beat_cnt_nxt  = '0;
      layer_cnt_nxt = '0;
      flags_clr_c   = 1'b1;
    end else begin
      case (state_q)
        IDLE, RECV: begin
          if (beat_hit_c) begin
            if (layer_ok_c) begin
              wr_en_c = 1'b1;
              if (last_beat_c) begin
                state_nxt     = FULL;
                beat_cnt_nxt  = '0;
                layer_cnt_nxt = '0;
              end else begin
                state_nxt = RECV;
                if (beat_cnt_q == BEAT_W'(2)) begin
                  beat_cnt_nxt  = '0;
                  layer_cnt_nxt = layer_cnt_q + LAYER_W'(1);
                end else begin
                  beat_cnt_nxt = beat_cnt_q + BEAT_W'(1);
                end
              end
            end else begin
              // Out-of-order layer: drop the beat, counters hold.
              seq_err_set_c = 1'b1;
            end
          end
          // Stream ended early; a finish together with the final beat is a
          // normal completion.
          if ((state_q == RECV) && finish_in && !(wr_en_c && last_beat_c)) begin
            incomplete_set_c = 1'b1;
            state_nxt        = IDLE;
            beat_cnt_nxt     = '0;
            layer_cnt_nxt    = '0;
          end
        end
        FULL: begin
          if (beat_hit_c) begin
            seq_err_set_c = 1'b1;
          end
        end
        default: begin
          state_nxt     = IDLE;
          beat_cnt_nxt  = '0;
          layer_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Read byte selection; only a complete set is visible.
  always_comb begin
    rd_row_c  = '0;
    rd_byte_c = '0;
    if ((state_q == FULL) && ({1'b0, rd_layer} < 3'(NUM_LAYERS))) begin
      rd_row_c = row_q[rd_layer];
      for (int k = 0; k < NUM_COLS; k++) begin
        if (rd_col == 4'(k)) begin
          rd_byte_c = rd_row_c[8*k +: 8];
        end
      end
    end
  end

  // State, counters and status flags.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      layer_cnt_q  <= '0;
      filter_ready <= 1'b0;
      seq_err      <= 1'b0;
      incomplete   <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      beat_cnt_q   <= beat_cnt_nxt;
      layer_cnt_q  <= layer_cnt_nxt;
      filter_ready <= (state_nxt == FULL);
      seq_err      <= flags_clr_c ? 1'b0 : (seq_err | seq_err_set_c);
      incomplete   <= flags_clr_c ? 1'b0 : (incomplete | incomplete_set_c);
    end
  end

  // Row storage: beat0 fills the top 24 bits, beats 1 and 2 the lower words.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        row_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      case (beat_cnt_q)
        2'd0:    row_q[layer_cnt_q][87:64] <= pkt_data_c[23:0];
        2'd1:    row_q[layer_cnt_q][63:32] <= pkt_data_c;
        default: row_q[layer_cnt_q][31:0]  <= pkt_data_c;
      endcase
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_byte_c : '0;
    end
  end

endmodule
